// File: rtl/bky_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bky_pkg
// Description : Shared types and constants for the Buckeye shift-register
//               sequencer (state encoding, chip count, default geometry).
// Revision    : 1.0 - initial release
// ============================================================================
package bky_pkg;

    // Six Buckeye shaper chips per DCFEB
    localparam int NUM_BKY      = 6;

    // 16 channels x 3 configuration bits per chip
    localparam int DEF_NBITS    = 48;

    // Shift-clock half period in system clock cycles
    localparam int DEF_HALF_PER = 4;

    // Sequencer states, explicitly encoded
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT_LO = 2'd1,
        ST_SHIFT_HI = 2'd2,
        ST_FINISH   = 2'd3
    } bky_state_e;

    // Replicate a single enable across all chip lanes and gate it with a mask
    function automatic logic [NUM_BKY:1] bky_gate(input logic en,
                                                   input logic [NUM_BKY:1] mask);
        return en ? mask : '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bky_rtn_sync.sv
`default_nettype none
// ============================================================================
// Module      : bky_rtn_sync
// Description : Two-flop synchronizer for the asynchronous Buckeye shift-out
//               return lines. Both stages reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module bky_rtn_sync
    import bky_pkg::*;
#(
    parameter int WIDTH = NUM_BKY
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Metastability filter: first stage may go metastable, second settles it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/bky_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bky_shift_ctrl
// Description : Serially loads one NBITS pattern (MSB first) into every
//               Buckeye selected by chip_mask, generating per-chip shift data
//               and shift clock. Optional readback captures the return stream
//               of one chip and flags chips whose returned contents differ
//               from the previously loaded pattern.
//               Build option: BKY_READBACK_EN enables the return synchronizer,
//               readback capture, rb_data and mismatch; without it those
//               outputs are tied to 0 and bky_rtn is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module bky_shift_ctrl
    import bky_pkg::*;
#(
    parameter int NBITS    = DEF_NBITS,
    parameter int HALF_PER = DEF_HALF_PER
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [NUM_BKY:1]   chip_mask,
    input  logic [NBITS-1:0]   shft_data,
    input  logic [2:0]         rb_sel,
    output logic               busy,
    output logic               done,
    output logic [NUM_BKY:1]   to_bky,
    output logic [NUM_BKY:1]   bky_clk,
    input  logic [NUM_BKY:1]   bky_rtn,
    output logic [NBITS-1:0]   rb_data,
    output logic [NUM_BKY:1]   mismatch
);

    localparam int c_bit_w = $clog2(NBITS);
    localparam int c_ph_w  = $clog2(HALF_PER);
    localparam logic [c_bit_w-1:0] c_bit_top = c_bit_w'(NBITS - 1);
    localparam logic [c_ph_w-1:0]  c_ph_last = c_ph_w'(HALF_PER - 1);

    // Sequencer state and counters
    bky_state_e          r_state;
    bky_state_e          w_state_nxt;
    logic [c_ph_w-1:0]   r_phase;
    logic [c_ph_w-1:0]   w_phase_nxt;
    logic [c_bit_w-1:0]  r_bit;
    logic [c_bit_w-1:0]  w_bit_nxt;

    // Single-cycle event strobes derived from the state machine
    logic                w_load;     // start accepted in IDLE
    logic                w_sample;   // last cycle of a SHIFT_LO half period
    logic                w_finish;   // final SHIFT_HI half period ends

    // Request latched at start
    logic [NUM_BKY:1]    r_mask;
    logic [NBITS-1:0]    r_pat;

    // Values the pattern/mask will have in the next cycle, so the output
    // registers can present the first bit in the cycle right after start
    logic [NUM_BKY:1]    w_mask_src;
    logic [NBITS-1:0]    w_pat_src;

    // Registered outputs and their next-cycle values
    logic                r_busy;
    logic                r_done;
    logic [NUM_BKY:1]    r_to_bky;
    logic [NUM_BKY:1]    r_bky_clk;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic [NUM_BKY:1]    w_to_bky_nxt;
    logic [NUM_BKY:1]    w_bky_clk_nxt;

    // Next-state, counter and output-decode logic
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_bit_nxt   = r_bit;
        w_load      = 1'b0;
        w_sample    = 1'b0;
        w_finish    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SHIFT_LO;
                    w_phase_nxt = '0;
                    w_bit_nxt   = c_bit_top;
                    w_load      = 1'b1;
                end
            end
            ST_SHIFT_LO: begin
                if (r_phase == c_ph_last) begin
                    w_state_nxt = ST_SHIFT_HI;
                    w_phase_nxt = '0;
                    w_sample    = 1'b1;
                end else begin
                    w_phase_nxt = r_phase + c_ph_w'(1);
                end
            end
            ST_SHIFT_HI: begin
                if (r_phase == c_ph_last) begin
                    w_phase_nxt = '0;
                    if (r_bit != '0) begin
                        w_state_nxt = ST_SHIFT_LO;
                        w_bit_nxt   = r_bit - c_bit_w'(1);
                    end else begin
                        w_state_nxt = ST_FINISH;
                        w_finish    = 1'b1;
                    end
                end else begin
                    w_phase_nxt = r_phase + c_ph_w'(1);
                end
            end
            ST_FINISH: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_mask_src = w_load ? chip_mask : r_mask;
        w_pat_src  = w_load ? shft_data : r_pat;

        // Data is held through both halves of a bit so it only ever changes
        // while the shift clock is low
        w_busy_nxt    = (w_state_nxt == ST_SHIFT_LO) || (w_state_nxt == ST_SHIFT_HI);
        w_done_nxt    = w_finish;
        w_to_bky_nxt  = bky_gate(w_busy_nxt && w_pat_src[w_bit_nxt], w_mask_src);
        w_bky_clk_nxt = bky_gate(w_state_nxt == ST_SHIFT_HI, w_mask_src);
    end

    // State, counters and latched request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_phase <= '0;
            r_bit   <= '0;
            r_mask  <= '0;
            r_pat   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_bit   <= w_bit_nxt;
            if (w_load) begin
                r_mask <= chip_mask;
                r_pat  <= shft_data;
            end
        end
    end

    // Output registers: every pad-facing line comes straight from a flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_to_bky  <= '0;
            r_bky_clk <= '0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_to_bky  <= w_to_bky_nxt;
            r_bky_clk <= w_bky_clk_nxt;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign to_bky  = r_to_bky;
    assign bky_clk = r_bky_clk;

`ifdef BKY_READBACK_EN

    logic [NUM_BKY:1]  w_rtn_sync;
    logic [2:0]        r_rb_sel;
    logic              w_rb_bit;
    logic [NUM_BKY:1]  w_exp_rep;
    logic [NBITS-1:0]  r_rb_shift;
    logic [NBITS-1:0]  r_rb_data;
    logic [NBITS-1:0]  r_exp;
    logic              r_exp_valid;
    logic [NUM_BKY:1]  r_mm_acc;
    logic [NUM_BKY:1]  r_mismatch;

    bky_rtn_sync #(
        .WIDTH (NUM_BKY)
    ) u_rtn_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bky_rtn),
        .q     (w_rtn_sync)
    );

    // Select the readback lane (0 for out-of-range selects) and replicate the
    // expected bit for the current position across all lanes
    always_comb begin
        w_rb_bit = 1'b0;
        for (int i = 1; i <= NUM_BKY; i++) begin
            if (r_rb_sel == 3'(i)) begin
                w_rb_bit = w_rtn_sync[i];
            end
        end
        w_exp_rep = {NUM_BKY{r_exp[r_bit]}};
    end

    // Readback capture and streaming compare against the previous pattern;
    // the chip presents its old contents MSB first, one bit per shift edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rb_sel    <= '0;
            r_rb_shift  <= '0;
            r_rb_data   <= '0;
            r_exp       <= '0;
            r_exp_valid <= 1'b0;
            r_mm_acc    <= '0;
            r_mismatch  <= '0;
        end else begin
            if (w_load) begin
                r_rb_sel   <= rb_sel;
                r_rb_shift <= '0;
                r_mm_acc   <= '0;
            end
            if (w_sample) begin
                r_rb_shift <= {r_rb_shift[NBITS-2:0], w_rb_bit};
                r_mm_acc   <= r_mm_acc | (w_rtn_sync ^ w_exp_rep);
            end
            if (w_finish) begin
                r_rb_data  <= r_rb_shift;
                r_mismatch <= r_mask & bky_gate(r_exp_valid, r_mm_acc);
                // An empty mask loads nothing, so the reference stays as is
                if (r_mask != '0) begin
                    r_exp       <= r_pat;
                    r_exp_valid <= 1'b1;
                end
            end
        end
    end

    assign rb_data  = r_rb_data;
    assign mismatch = r_mismatch;

`else

    logic w_unused_rb;
    assign w_unused_rb = ^{bky_rtn, rb_sel, w_sample, w_finish};

    assign rb_data  = '0;
    assign mismatch = '0;

`endif

endmodule
`default_nettype wire
